dmi_jtag_tap: RTL and testbench

//  IEEE 1149.1 TAP controller and RISC-V DTM register file in the TCK domain. Decodes TMS/TDI and holds IR, IDCODE, DTMCS, DMI and BYPASS.

---
 rtl/dmi_tap_pkg.sv | 49 ++++
 rtl/dmi_tap_fsm.sv | 58 +++++
 rtl/dmi_jtag_tap.sv | 170 +++++++++++++++++
 tb/tb_dmi_jtag_tap.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmi_tap_pkg.sv
// Shared types and constants for the RISC-V JTAG DTM: TAP states, IR codes,
// DTMCS strobe bit positions and DMI op encodings.
package dmi_tap_pkg;

  // IEEE 1149.1 reference state encoding
  typedef enum logic [3:0] {
    TAP_EXIT2_DR   = 4'h0,
    TAP_EXIT1_DR   = 4'h1,
    TAP_SHIFT_DR   = 4'h2,
    TAP_PAUSE_DR   = 4'h3,
    TAP_SELECT_IR  = 4'h4,
    TAP_UPDATE_DR  = 4'h5,
    TAP_CAPTURE_DR = 4'h6,
    TAP_SELECT_DR  = 4'h7,
    TAP_EXIT2_IR   = 4'h8,
    TAP_EXIT1_IR   = 4'h9,
    TAP_SHIFT_IR   = 4'hA,
    TAP_PAUSE_IR   = 4'hB,
    TAP_RUN_IDLE   = 4'hC,
    TAP_UPDATE_IR  = 4'hD,
    TAP_CAPTURE_IR = 4'hE,
    TAP_RESET      = 4'hF
  } tap_state_e;

  typedef enum logic [1:0] {SEL_IDCODE, SEL_DTMCS, SEL_DMI, SEL_BYPASS} dr_sel_e;

  localparam int unsigned IR_W = 5;
  localparam logic [IR_W-1:0] IR_IDCODE = 5'h01;
  localparam logic [IR_W-1:0] IR_DTMCS  = 5'h10;
  localparam logic [IR_W-1:0] IR_DMI    = 5'h11;
  localparam logic [IR_W-1:0] IR_BYPASS = 5'h1F;

  localparam int unsigned DTMCS_DMIRESET     = 16;
  localparam int unsigned DTMCS_DMIHARDRESET = 17;

  localparam logic [1:0] DMI_OP_READ  = 2'b01;
  localparam logic [1:0] DMI_OP_WRITE = 2'b10;

  // Unknown IR codes fall back to BYPASS.
  function automatic dr_sel_e decode_ir(input logic [IR_W-1:0] ir);
    case (ir)
      IR_IDCODE: return SEL_IDCODE;
      IR_DTMCS:  return SEL_DTMCS;
      IR_DMI:    return SEL_DMI;
      default:   return SEL_BYPASS;
    endcase
  endfunction

endpackage

// File: rtl/dmi_tap_fsm.sv
// 16-state IEEE 1149.1 TAP controller; publishes the current state and
// decoded capture/shift/update strobes for the register file.
module dmi_tap_fsm
  import dmi_tap_pkg::*;
(
  input  logic       tck,
  input  logic       trst_n,
  input  logic       tms,
  output tap_state_e state_o,
  output logic       capture_ir_o,
  output logic       shift_ir_o,
  output logic       update_ir_o,
  output logic       capture_dr_o,
  output logic       shift_dr_o,
  output logic       update_dr_o
);

  tap_state_e state_q, state_d;

  always_comb begin
    // NOTE: assign a default before the case so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      TAP_RESET:      state_d = tms ? TAP_RESET     : TAP_RUN_IDLE;
      TAP_RUN_IDLE:   state_d = tms ? TAP_SELECT_DR : TAP_RUN_IDLE;
      TAP_SELECT_DR:  state_d = tms ? TAP_SELECT_IR : TAP_CAPTURE_DR;
      TAP_CAPTURE_DR: state_d = tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
      TAP_SHIFT_DR:   state_d = tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
      TAP_EXIT1_DR:   state_d = tms ? TAP_UPDATE_DR : TAP_PAUSE_DR;
      TAP_PAUSE_DR:   state_d = tms ? TAP_EXIT2_DR  : TAP_PAUSE_DR;
      TAP_EXIT2_DR:   state_d = tms ? TAP_UPDATE_DR : TAP_SHIFT_DR;
      TAP_UPDATE_DR:  state_d = tms ? TAP_SELECT_DR : TAP_RUN_IDLE;
      TAP_SELECT_IR:  state_d = tms ? TAP_RESET     : TAP_CAPTURE_IR;
      TAP_CAPTURE_IR: state_d = tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
      TAP_SHIFT_IR:   state_d = tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
      TAP_EXIT1_IR:   state_d = tms ? TAP_UPDATE_IR : TAP_PAUSE_IR;
      TAP_PAUSE_IR:   state_d = tms ? TAP_EXIT2_IR  : TAP_PAUSE_IR;
      TAP_EXIT2_IR:   state_d = tms ? TAP_UPDATE_IR : TAP_SHIFT_IR;
      TAP_UPDATE_IR:  state_d = tms ? TAP_SELECT_DR : TAP_RUN_IDLE;
      default:        state_d = TAP_RESET;
    endcase
  end

  always_ff @(posedge tck or negedge trst_n) begin
    // NOTE: non-blocking assignment for all flop updates so every register samples pre-edge values.
    if (!trst_n) state_q <= TAP_RESET;
    else         state_q <= state_d;
  end

  assign state_o      = state_q;
  assign capture_ir_o = (state_q == TAP_CAPTURE_IR);
  assign shift_ir_o   = (state_q == TAP_SHIFT_IR);
  assign update_ir_o  = (state_q == TAP_UPDATE_IR);
  assign capture_dr_o = (state_q == TAP_CAPTURE_DR);
  assign shift_dr_o   = (state_q == TAP_SHIFT_DR);
  assign update_dr_o  = (state_q == TAP_UPDATE_DR);

endmodule

// File: rtl/dmi_jtag_tap.sv
// RISC-V DTM in the TCK domain: IR, IDCODE/DTMCS/DMI/BYPASS data registers and
// DMI request strobes. Define RV_DMI_BUSY_GUARD_EN to drop DMI ops while busy/failed.
module dmi_jtag_tap
  import dmi_tap_pkg::*;
#(
  parameter int unsigned AWIDTH      = 7,
  parameter logic [31:0] IDCODE      = 32'h1000_0A6F,
  parameter logic [3:0]  DTM_VERSION = 4'd1
) (
  input  logic        tck,
  input  logic        trst_n,
  input  logic        tms,
  input  logic        tdi,
  output logic        tdo,
  output logic        tdo_en,
  input  logic [31:0] rd_data,
  input  logic [1:0]  rd_status,
  input  logic [2:0]  idle,
  output logic [31:0] wr_data,
  output logic [31:0] wr_addr,
  output logic        wr_intf,
  output logic        wr_enab,
  output logic        dmi_reset,
  output logic        dmi_hard_reset
);

  localparam int unsigned DMI_W = AWIDTH + 34;
  localparam logic [5:0]  ABITS = 6'(AWIDTH);

  tap_state_e tap_state;
  logic capture_ir, shift_ir, update_ir, capture_dr, shift_dr, update_dr;

  dmi_tap_fsm u_fsm (
    .tck          (tck),
    .trst_n       (trst_n),
    .tms          (tms),
    .state_o      (tap_state),
    .capture_ir_o (capture_ir),
    .shift_ir_o   (shift_ir),
    .update_ir_o  (update_ir),
    .capture_dr_o (capture_dr),
    .shift_dr_o   (shift_dr),
    .update_dr_o  (update_dr)
  );

  logic [IR_W-1:0]   ir_q, ir_d, ir_sr_q, ir_sr_d;
  logic [DMI_W-1:0]  dr_q, dr_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic wr_intf_q, wr_intf_d, wr_enab_q, wr_enab_d;
  logic dmi_reset_q, dmi_reset_d, dmi_hard_reset_q, dmi_hard_reset_d;
  logic tdo_q, tdo_d, tdo_en_q, tdo_en_d;
  logic dmi_blocked;
  dr_sel_e dr_sel;
  logic [1:0] dmi_op;

`ifdef RV_DMI_BUSY_GUARD_EN
  assign dmi_blocked = rd_status[1];
`else
  assign dmi_blocked = 1'b0;
`endif

  assign dr_sel = decode_ir(ir_q);
  assign dmi_op = dr_q[1:0];

  always_comb begin
    ir_d             = ir_q;
    ir_sr_d          = ir_sr_q;
    dr_d             = dr_q;
    addr_d           = addr_q;
    data_d           = data_q;
    wr_intf_d        = 1'b0;
    wr_enab_d        = 1'b0;
    dmi_reset_d      = 1'b0;
    dmi_hard_reset_d = 1'b0;

    if (tap_state == TAP_RESET) ir_d = IR_IDCODE;
    if (capture_ir)             ir_sr_d = 5'b00001;
    if (shift_ir)               ir_sr_d = {tdi, ir_sr_q[IR_W-1:1]};
    if (update_ir)              ir_d = ir_sr_q;

    if (capture_dr) begin
      case (dr_sel)
        SEL_IDCODE: dr_d = DMI_W'(IDCODE);
        SEL_DTMCS:  dr_d = DMI_W'({17'b0, idle, rd_status, ABITS, DTM_VERSION});
        SEL_DMI:    dr_d = {addr_q, rd_data, rd_status};
        default:    dr_d = '0;
      endcase
    end

    // tdi enters at the top of whichever register length is currently selected
    if (shift_dr) begin
      case (dr_sel)
        SEL_IDCODE, SEL_DTMCS: dr_d = DMI_W'({tdi, dr_q[31:1]});
        SEL_DMI:               dr_d = {tdi, dr_q[DMI_W-1:1]};
        default:               dr_d = DMI_W'(tdi);
      endcase
    end

    if (update_dr) begin
      case (dr_sel)
        SEL_DTMCS: begin
          dmi_reset_d      = dr_q[DTMCS_DMIRESET];
          dmi_hard_reset_d = dr_q[DTMCS_DMIHARDRESET];
        end
        SEL_DMI: begin
          if (!dmi_blocked) begin
            addr_d    = dr_q[DMI_W-1:34];
            data_d    = dr_q[33:2];
            wr_intf_d = (dmi_op == DMI_OP_READ) || (dmi_op == DMI_OP_WRITE);
            wr_enab_d = (dmi_op == DMI_OP_WRITE);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      ir_q             <= IR_IDCODE;
      ir_sr_q          <= '0;
      dr_q             <= '0;
      addr_q           <= '0;
      data_q           <= '0;
      wr_intf_q        <= 1'b0;
      wr_enab_q        <= 1'b0;
      dmi_reset_q      <= 1'b0;
      dmi_hard_reset_q <= 1'b0;
    end else begin
      ir_q             <= ir_d;
      ir_sr_q          <= ir_sr_d;
      dr_q             <= dr_d;
      addr_q           <= addr_d;
      data_q           <= data_d;
      wr_intf_q        <= wr_intf_d;
      wr_enab_q        <= wr_enab_d;
      dmi_reset_q      <= dmi_reset_d;
      dmi_hard_reset_q <= dmi_hard_reset_d;
    end
  end

  // tdo launches on the falling edge so the host samples it on the next rising edge
  always_comb begin
    tdo_d    = tdo_q;
    tdo_en_d = shift_ir | shift_dr;
    if (shift_ir)      tdo_d = ir_sr_q[0];
    else if (shift_dr) tdo_d = dr_q[0];
  end

  always_ff @(negedge tck or negedge trst_n) begin
    if (!trst_n) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_en_q <= tdo_en_d;
    end
  end

  assign tdo            = tdo_q;
  assign tdo_en         = tdo_en_q;
  assign wr_addr        = 32'(addr_q);
  assign wr_data        = data_q;
  assign wr_intf        = wr_intf_q;
  assign wr_enab        = wr_enab_q;
  assign dmi_reset      = dmi_reset_q;
  assign dmi_hard_reset = dmi_hard_reset_q;

endmodule

// File: tb/tb_dmi_jtag_tap.sv
// Scoreboard bench for dmi_jtag_tap: stimulus pushes expected tdo bits and strobes,
// monitors pop and compare. Honours RV_DMI_BUSY_GUARD_EN when set.
module tb_dmi_jtag_tap;

  localparam int          AW      = 7;
  localparam int          DW      = AW + 34;
  localparam logic [31:0] IDC     = 32'h1000_0A6F;
  localparam logic [3:0]  DTM_VER = 4'd1;

  logic        tck = 1'b0, trst_n = 1'b0, tms = 1'b1, tdi = 1'b0;
  logic        tdo, tdo_en;
  logic [31:0] rd_data = '0;
  logic [1:0]  rd_status = '0;
  logic [2:0]  idle = '0;
  logic [31:0] wr_data, wr_addr;
  logic        wr_intf, wr_enab, dmi_reset, dmi_hard_reset;

  dmi_jtag_tap dut (
    .tck            (tck),
    .trst_n         (trst_n),
    .tms            (tms),
    .tdi            (tdi),
    .tdo            (tdo),
    .tdo_en         (tdo_en),
    .rd_data        (rd_data),
    .rd_status      (rd_status),
    .idle           (idle),
    .wr_data        (wr_data),
    .wr_addr        (wr_addr),
    .wr_intf        (wr_intf),
    .wr_enab        (wr_enab),
    .dmi_reset      (dmi_reset),
    .dmi_hard_reset (dmi_hard_reset)
  );

  always #5 tck = ~tck;

  typedef struct packed {
    logic        intf, enab, rst, hrst;
    logic [31:0] addr, data;
  } pulse_t;

  int     n_tests = 0;
  int     n_fail  = 0;
  bit     tdo_exp_q[$];
  pulse_t pulse_q[$];
  pulse_t mon_e;
  bit     tdo_chk_en = 1'b1;

  // reference model state
  logic [4:0]    m_ir   = 5'h01;
  logic [AW-1:0] m_addr = '0;
  logic [31:0]   m_data = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int dr_len(input logic [4:0] ir);
    case (ir)
      5'h01, 5'h10: return 32;
      5'h11:        return DW;
      default:      return 1;
    endcase
  endfunction

  function automatic logic [63:0] dr_capture(input logic [4:0] ir);
    case (ir)
      5'h01:   return 64'(IDC);
      5'h10:   return 64'(DTM_VER) | (64'(AW) << 4) | (64'(rd_status) << 10) | (64'(idle) << 12);
      5'h11:   return (64'(m_addr) << 34) | (64'(rd_data) << 2) | 64'(rd_status);
      default: return 64'd0;
    endcase
  endfunction

  function automatic bit dmi_guarded();
`ifdef RV_DMI_BUSY_GUARD_EN
    return rd_status == 2'b10 || rd_status == 2'b11;
`else
    return 1'b0;
`endif
  endfunction

  task automatic step(input bit m, input bit d);
    tms = m;
    tdi = d;
    @(posedge tck);
    #1;
  endtask

  // Run-Test/Idle -> IR scan -> Run-Test/Idle
  task automatic scan_ir(input logic [4:0] code);
    for (int i = 0; i < 5; i++) if (tdo_chk_en) tdo_exp_q.push_back(i == 0);
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 5; i++) step(i == 4, code[i]);
    step(1, 0); step(0, 0);
    m_ir = code;
  endtask

  // Run-Test/Idle -> DR scan -> Run-Test/Idle, predicting capture and update effects
  task automatic scan_dr(input logic [63:0] data);
    int          len;
    logic [63:0] cap;
    pulse_t      e;
    len = dr_len(m_ir);
    cap = dr_capture(m_ir);
    for (int i = 0; i < len; i++) if (tdo_chk_en) tdo_exp_q.push_back(cap[i]);
    if (m_ir == 5'h10 && (data[16] || data[17])) begin
      e = '{intf: 1'b0, enab: 1'b0, rst: data[16], hrst: data[17],
            addr: 32'(m_addr), data: m_data};
      pulse_q.push_back(e);
    end else if (m_ir == 5'h11 && !dmi_guarded()) begin
      m_addr = data[DW-1:34];
      m_data = data[33:2];
      if (data[1:0] == 2'b01 || data[1:0] == 2'b10) begin
        e = '{intf: 1'b1, enab: data[1:0] == 2'b10, rst: 1'b0, hrst: 1'b0,
              addr: 32'(m_addr), data: m_data};
        pulse_q.push_back(e);
      end
    end
    step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < len; i++) step(i == len - 1, data[i]);
    step(1, 0); step(0, 0);
  endtask

  function automatic logic [63:0] dmi_word(input logic [6:0] a, input logic [31:0] d,
                                           input logic [1:0] op);
    return 64'({a, d, op});
  endfunction

  // tdo monitor: one bit per shift cycle, sampled on the rising edge
  always @(posedge tck) begin
    if (trst_n && tdo_en && tdo_chk_en) begin
      if (tdo_exp_q.size() == 0) check("tdo_unexpected", 64'(tdo_en), 64'd0);
      else check("tdo_bit", 64'(tdo), 64'(tdo_exp_q.pop_front()));
    end
  end

  // strobe monitor: each strobe cycle must match one predicted event
  always @(negedge tck) begin
    if (wr_intf || wr_enab || dmi_reset || dmi_hard_reset) begin
      if (pulse_q.size() == 0) begin
        check("pulse_unexpected", 64'({wr_intf, wr_enab, dmi_reset, dmi_hard_reset}), 64'd0);
      end else begin
        mon_e = pulse_q.pop_front();
        check("pulse_kind", 64'({wr_intf, wr_enab, dmi_reset, dmi_hard_reset}),
              64'({mon_e.intf, mon_e.enab, mon_e.rst, mon_e.hrst}));
        check("pulse_addr", 64'(wr_addr), 64'(mon_e.addr));
        check("pulse_data", 64'(wr_data), 64'(mon_e.data));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  code;
    logic [63:0] data;

    // reset state
    repeat (2) @(posedge tck);
    #1;
    check("rst_tdo", 64'(tdo), 64'd0);
    check("rst_tdo_en", 64'(tdo_en), 64'd0);
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    check("rst_wr_data", 64'(wr_data), 64'd0);
    check("rst_strobes", 64'({wr_intf, wr_enab, dmi_reset, dmi_hard_reset}), 64'd0);
    trst_n = 1'b1;
    step(0, 0);

    // IDCODE selected out of reset
    scan_dr(64'h0);

    // 5x tms=1 from Shift-DR returns IR to IDCODE
    scan_ir(5'h1F);
    tdo_chk_en = 1'b0;
    step(1, 0); step(0, 0); step(0, 0); step(0, 1); step(0, 1);
    repeat (5) step(1, 0);
    step(0, 0);
    tdo_chk_en = 1'b1;
    m_ir = 5'h01;
    scan_dr(64'h0);
    scan_ir(5'h01);
    scan_dr(64'h0);

    // DMI write then read back
    scan_ir(5'h11);
    scan_dr(dmi_word(7'h10, 32'hDEAD_BEEF, 2'b10));
    check("dir_wr_addr", 64'(wr_addr), 64'h10);
    check("dir_wr_data", 64'(wr_data), 64'hDEAD_BEEF);
    scan_dr(dmi_word(7'h11, 32'h0, 2'b01));
    rd_data = 32'h1234_5678;
    scan_dr(dmi_word(7'h11, 32'h0, 2'b01));
    scan_dr(dmi_word(7'h11, 32'h0, 2'b00));
    scan_dr(dmi_word(7'h11, 32'h0, 2'b11));

    // DTMCS strobes and capture fields
    scan_ir(5'h10);
    idle = 3'd5;
    rd_status = 2'b10;
    scan_dr(64'h1 << 16);
    scan_dr(64'h3 << 16);
    scan_dr(64'h1 << 17);

    // busy status during a DMI write
    scan_ir(5'h11);
    rd_status = 2'b11;
    scan_dr(dmi_word(7'h22, 32'hCAFE_F00D, 2'b10));
    rd_status = 2'b00;
    scan_dr(dmi_word(7'h23, 32'h0, 2'b01));

    // randomized scans
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 4))
        0:       code = 5'h01;
        1:       code = 5'h10;
        2, 3:    code = 5'h11;
        default: code = 5'($urandom);
      endcase
      rd_data = $urandom;
      idle    = 3'($urandom);
      case ($urandom_range(0, 2))
        0:       rd_status = 2'b00;
        1:       rd_status = 2'b10;
        default: rd_status = 2'b11;
      endcase
      scan_ir(code);
      for (int k = 0; k < 2; k++) begin
        data = {32'($urandom), 32'($urandom)};
        if (code == 5'h11) data[1:0] = 2'($urandom_range(1, 2));
        scan_dr(data);
      end
    end

    // trst_n mid-shift aborts the scan
    rd_status = 2'b00;
    scan_ir(5'h11);
    scan_dr(dmi_word(7'h35, 32'h5A5A_0001, 2'b10));
    tdo_chk_en = 1'b0;
    step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 20; i++) step(0, i < 2 ? (i == 1) : 1'($urandom));
    trst_n = 1'b0;
    #2;
    check("abort_wr_addr", 64'(wr_addr), 64'd0);
    check("abort_wr_data", 64'(wr_data), 64'd0);
    check("abort_tdo_en", 64'(tdo_en), 64'd0);
    tms = 1'b1;
    @(posedge tck);
    #1;
    trst_n = 1'b1;
    m_ir = 5'h01;
    m_addr = '0;
    m_data = '0;
    step(0, 0);
    tdo_chk_en = 1'b1;
    scan_dr(64'h0);
    scan_ir(5'h11);
    scan_dr(dmi_word(7'h01, 32'h0, 2'b01));

    repeat (4) step(0, 0);
    check("tdo_queue_drained", 64'(tdo_exp_q.size()), 64'd0);
    check("pulse_queue_drained", 64'(pulse_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
